ulpi_init_seq: RTL and testbench
================================

ULPI_INIT_SEQ -- requirements
Module: ulpi_init_seq

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning max re-issues of one step after REG_FAIL.
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning cycles allowed per wait before error.
REQ-003 SHALL have parameter FUNC_CTRL_VAL, default 8'h45, meaning final Function Control value (FS, TermSelect, SuspendM).
REQ-004 CLK_60M  in  1  clock; all logic on rising edge.
REQ-005 NRST_A_USB  in  1  reset, asynchronous, active-low.
REQ-006 RESTART  in  1  one-cycle pulse; restarts sequence from step 0 when in DONE or ERROR.
REQ-007 READY  in  1  ULPI register engine ready.
REQ-008 REG_DONE  in  1  register op completed.
REQ-009 REG_FAIL  in  1  register op aborted by PHY.
REQ-010 REG_DATA_O  in  8  read data, valid while REG_DONE=1 on a read.
REQ-011 REG_EN  out  1  single-cycle op strobe.
REQ-012 REG_RW  out  1  1=write, 0=read.
REQ-013 REG_ADDR  out  6  register address.
REQ-014 REG_DATA_I  out  8  write data.
REQ-015 VENDOR_ID  out  8  value read from address 6'h00.
REQ-016 STEP  out  3  current step index.
REQ-017 INIT_DONE  out  1  level; sequence completed and verified.
REQ-018 INIT_ERR  out  1  level; sequence aborted; STEP holds failing step.

Function
REQ-019 Step table SHALL be fixed: 0 read 6'h00 -> VENDOR_ID; 1 write 6'h04 8'h20 (PHY reset); 2 write 6'h0A 8'h00; 3 write 6'h04 FUNC_CTRL_VAL; 4 read 6'h04, compare to FUNC_CTRL_VAL.
REQ-020 States SHALL be WAIT_RDY, ISSUE, WAIT_RSP, RST_LOW, RST_HIGH, DONE, ERROR.
REQ-021 WAIT_RDY -> ISSUE when READY=1 and REG_DONE=0 and REG_FAIL=0.
REQ-022 ISSUE SHALL assert REG_EN for exactly one cycle, then go to WAIT_RSP.
REQ-023 REG_RW/REG_ADDR/REG_DATA_I SHALL be registered, set on entry to WAIT_RDY, held stable through WAIT_RSP.
REQ-024 WAIT_RSP, REG_FAIL=1: retry counter+1 -> WAIT_RDY; if counter already = MAX_RETRY -> ERROR.
REQ-025 WAIT_RSP, REG_DONE=1 and REG_FAIL=1 same cycle: REG_FAIL SHALL take priority.
REQ-026 WAIT_RSP, REG_DONE=1: step 0 latches REG_DATA_O into VENDOR_ID; step 1 -> RST_LOW; step 4 -> DONE if REG_DATA_O==FUNC_CTRL_VAL else ERROR; other steps -> next step WAIT_RDY; retry counter cleared on step advance.
REQ-027 RST_LOW -> RST_HIGH when READY=0; RST_HIGH -> step 2 WAIT_RDY when READY=1.
REQ-028 Timeout counter (10 bits min) SHALL clear on every state change and, in WAIT_RDY, WAIT_RSP, RST_LOW, RST_HIGH, reaching TIMEOUT SHALL force ERROR.
REQ-029 DONE SHALL drive INIT_DONE=1; ERROR SHALL drive INIT_ERR=1; both held until RESTART or reset.
REQ-030 RESTART SHALL be ignored outside DONE/ERROR; in DONE/ERROR it clears INIT_DONE, INIT_ERR, retry counter, STEP=0 -> WAIT_RDY.
REQ-031 REG_EN SHALL never be asserted in any state other than ISSUE.

Reset
REQ-032 On NRST_A_USB=0: state WAIT_RDY, STEP=0, REG_EN=0, REG_RW=0, REG_ADDR=0, REG_DATA_I=0, VENDOR_ID=0, INIT_DONE=0, INIT_ERR=0, counters 0.
REQ-033 Reset asserted mid-operation SHALL abort immediately; no REG_EN pulse after reset release until READY observed in WAIT_RDY.

Verification
REQ-034 Nominal: PHY model returns 8'h24 on read 0x00, READY drops 5 cycles after step-1 DONE, readback 8'h45 -> VENDOR_ID=8'h24, INIT_DONE=1, exactly 5 REG_EN pulses.
REQ-035 Single abort: REG_FAIL on first step-2 attempt -> step 2 reissued once, INIT_DONE=1, 6 REG_EN pulses total.
REQ-036 Persistent abort: REG_FAIL on every step-3 attempt -> 4 step-3 pulses, INIT_ERR=1, STEP=3.
REQ-037 Readback mismatch: step-4 returns 8'h41 -> INIT_ERR=1, STEP=4, INIT_DONE=0.
REQ-038 Timeout: READY held 1 after step-1 DONE -> INIT_ERR=1, STEP=1 after TIMEOUT cycles in RST_LOW; RESTART pulse -> STEP=0, INIT_ERR=0.
REQ-039 REG_DONE and REG_FAIL together in step 0 -> treated as fail, VENDOR_ID unchanged, step 0 reissued.

Source files
------------

// File: rtl/ulpi_init_seq.sv
// ULPI PHY bring-up sequencer: reads the vendor ID, resets the PHY, then programs
// and verifies Function Control through the ULPI register engine.
module ulpi_init_seq #(
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT       = 1023,
  parameter logic [7:0] FUNC_CTRL_VAL = 8'h45
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       RESTART,
  input  logic       READY,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic [7:0] REG_DATA_O,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  output logic [7:0] VENDOR_ID,
  output logic [2:0] STEP,
  output logic       INIT_DONE,
  output logic       INIT_ERR
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_RDY, S_ISSUE, S_WAIT_RSP, S_RST_LOW, S_RST_HIGH, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [CW-1:0] retry_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_MAX);

  // {rw, addr, wdata} for each step of the bring-up table
  function automatic logic [14:0] step_op(input logic [2:0] s);
    case (s)
      3'd0:    step_op = {1'b0, 6'h00, 8'h00};
      3'd1:    step_op = {1'b1, 6'h04, 8'h20};
      3'd2:    step_op = {1'b1, 6'h0A, 8'h00};
      3'd3:    step_op = {1'b1, 6'h04, FUNC_CTRL_VAL};
      default: step_op = {1'b0, 6'h04, 8'h00};
    endcase
  endfunction

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state      <= S_WAIT_RDY;
      STEP       <= '0;
      REG_EN     <= 1'b0;
      REG_RW     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA_I <= '0;
      VENDOR_ID  <= '0;
      INIT_DONE  <= 1'b0;
      INIT_ERR   <= 1'b0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
    end else begin
      REG_EN  <= 1'b0;
      tmo_cnt <= '0;
      case (state)
        S_WAIT_RDY:
          if (READY && !REG_DONE && !REG_FAIL) begin
            state  <= S_ISSUE;
            REG_EN <= 1'b1;
          end else if (tmo_hit) begin
            state    <= S_ERROR;
            INIT_ERR <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        S_ISSUE: state <= S_WAIT_RSP;
        S_WAIT_RSP:
          // an abort wins even when the engine also flags completion
          if (REG_FAIL) begin
            if (retry_cnt == RETRY_MAX) begin
              state    <= S_ERROR;
              INIT_ERR <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_WAIT_RDY;
            end
          end else if (REG_DONE) begin
            case (STEP)
              3'd1: begin
                retry_cnt <= '0;
                state     <= S_RST_LOW;
              end
              3'd4:
                if (REG_DATA_O == FUNC_CTRL_VAL) begin
                  state     <= S_DONE;
                  INIT_DONE <= 1'b1;
                end else begin
                  state    <= S_ERROR;
                  INIT_ERR <= 1'b1;
                end
              default: begin
                if (STEP == 3'd0) VENDOR_ID <= REG_DATA_O;
                retry_cnt <= '0;
                STEP      <= STEP + 3'd1;
                {REG_RW, REG_ADDR, REG_DATA_I} <= step_op(STEP + 3'd1);
                state     <= S_WAIT_RDY;
              end
            endcase
          end else if (tmo_hit) begin
            state    <= S_ERROR;
            INIT_ERR <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        S_RST_LOW:
          if (!READY) state <= S_RST_HIGH;
          else if (tmo_hit) begin
            state    <= S_ERROR;
            INIT_ERR <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        S_RST_HIGH:
          if (READY) begin
            STEP  <= 3'd2;
            {REG_RW, REG_ADDR, REG_DATA_I} <= step_op(3'd2);
            state <= S_WAIT_RDY;
          end else if (tmo_hit) begin
            state    <= S_ERROR;
            INIT_ERR <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        S_DONE, S_ERROR:
          if (RESTART) begin
            INIT_DONE <= 1'b0;
            INIT_ERR  <= 1'b0;
            retry_cnt <= '0;
            STEP      <= '0;
            {REG_RW, REG_ADDR, REG_DATA_I} <= step_op(3'd0);
            state     <= S_WAIT_RDY;
          end
        default: begin
          state    <= S_ERROR;
          INIT_ERR <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_init_seq.sv
// Randomized bench for ulpi_init_seq: a PHY/register-engine model answers the
// strobes and a step-table model predicts pulses, final flags and STEP.
module tb_ulpi_init_seq;
  localparam int         MAX_RETRY = 3;
  localparam int         TIMEOUT   = 1023;
  localparam logic [7:0] FUNC      = 8'h45;

  logic       CLK_60M = 1'b0;
  logic       NRST_A_USB = 1'b0;
  logic       RESTART = 1'b0;
  logic       READY, REG_DONE, REG_FAIL;
  logic [7:0] REG_DATA_O;
  logic       REG_EN, REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I, VENDOR_ID;
  logic [2:0] STEP;
  logic       INIT_DONE, INIT_ERR;

  always #8 CLK_60M = ~CLK_60M;

  ulpi_init_seq #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .FUNC_CTRL_VAL(FUNC)) dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .RESTART(RESTART), .READY(READY),
    .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL), .REG_DATA_O(REG_DATA_O),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
    .VENDOR_ID(VENDOR_ID), .STEP(STEP), .INIT_DONE(INIT_DONE), .INIT_ERR(INIT_ERR)
  );

  int total = 0;
  int bad = 0;

  // PHY model configuration and state
  logic [7:0] cfg_vid = 8'h24, cfg_rb = FUNC;
  int  cfg_fs = -1, cfg_fn = 0;
  bit  cfg_both = 0, cfg_hold = 0, force_low = 0;
  int  ops_q[$];
  int  attempts[8];
  int  pend, pend_step, drop_cnt, low_cnt, en_viol, cyc, s1_done_cyc, phy_s;
  bit  pend_fail, pend_both, ready_int, prev_en;
  logic [7:0] pend_data;

  // expected outcome from the step-table model
  int exp_steps[16];
  int exp_n, exp_step;
  bit exp_done, exp_vid_ok;

  function automatic int classify(logic rw, logic [5:0] a, logic [7:0] d);
    if (!rw && a == 6'h00) return 0;
    if (rw && a == 6'h04 && d == 8'h20) return 1;
    if (rw && a == 6'h0A && d == 8'h00) return 2;
    if (rw && a == 6'h04 && d == FUNC) return 3;
    if (!rw && a == 6'h04) return 4;
    return 7;
  endfunction

  task automatic phy_reset();
    pend = 0; drop_cnt = 0; low_cnt = 0; ready_int = 1; prev_en = 0;
    en_viol = 0; s1_done_cyc = 0;
    ops_q.delete();
    foreach (attempts[i]) attempts[i] = 0;
  endtask

  initial begin
    READY = 1'b1; REG_DONE = 1'b0; REG_FAIL = 1'b0; REG_DATA_O = 8'h00; cyc = 0;
    phy_reset();
    forever begin
      @(negedge CLK_60M);
      cyc++;
      REG_DONE = 1'b0;
      REG_FAIL = 1'b0;
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) begin
          ready_int = 1'b0;
          low_cnt = $urandom_range(1, 6);
        end
      end else if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) ready_int = 1'b1;
      end
      READY = ready_int && !force_low;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          REG_FAIL = pend_fail;
          REG_DONE = !pend_fail || pend_both;
          REG_DATA_O = pend_data;
          if (!pend_fail && pend_step == 1) begin
            s1_done_cyc = cyc;
            if (!cfg_hold) drop_cnt = 5;
          end
        end
      end
      if (REG_EN === 1'b1) begin
        phy_s = classify(REG_RW, REG_ADDR, REG_DATA_I);
        if (prev_en) en_viol++;
        ops_q.push_back(phy_s);
        attempts[phy_s]++;
        pend_step = phy_s;
        pend_fail = (phy_s == cfg_fs) && (attempts[phy_s] <= cfg_fn);
        pend_both = pend_fail && cfg_both;
        pend_data = pend_both ? 8'hEE : (phy_s == 0) ? cfg_vid : (phy_s == 4) ? cfg_rb : 8'h00;
        pend = $urandom_range(1, 3);
      end
      prev_en = (REG_EN === 1'b1);
    end
  end

  // fs = step whose first fn attempts abort (-1: none); hold = READY never drops after step 1
  task automatic model_run(input int fs, input int fn, input logic [7:0] rb, input bit hold);
    exp_n = 0; exp_done = 0; exp_step = 0; exp_vid_ok = 0;
    for (int s = 0; s < 5; s++) begin
      int fails, tries;
      fails = (s == fs) ? fn : 0;
      tries = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
      for (int a = 0; a < tries; a++) exp_steps[exp_n++] = s;
      exp_step = s;
      if (fails > MAX_RETRY) return;
      if (s == 0) exp_vid_ok = 1;
      if (s == 1 && hold) return;
      if (s == 4) begin
        exp_done = (rb == FUNC);
        return;
      end
    end
  endtask

  task automatic start_scn(input logic [7:0] vid, input int fs, input int fn, input bit both,
                           input logic [7:0] rb, input bit hold);
    @(negedge CLK_60M);
    NRST_A_USB = 1'b0;
    RESTART = 1'b0;
    @(posedge CLK_60M);
    cfg_vid = vid; cfg_fs = fs; cfg_fn = fn; cfg_both = both; cfg_rb = rb; cfg_hold = hold;
    phy_reset();
    model_run(fs, fn, rb, hold);
    @(negedge CLK_60M);
    @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
  endtask

  task automatic wait_term(input int budget, output bit hit);
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK_60M);
      if (INIT_DONE === 1'b1 || INIT_ERR === 1'b1) hit = 1;
    end
  endtask

  task automatic wait_ops(input int n, input int budget, output bit hit);
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK_60M);
      if (ops_q.size() >= n) hit = 1;
    end
  endtask

  task automatic test_reset();
    NRST_A_USB = 1'b0;
    repeat (3) @(negedge CLK_60M);
    total += 8;
    if (REG_EN !== 1'b0) begin bad++; $display("FAIL rst_reg_en: got %b want 0", REG_EN); end
    if (REG_RW !== 1'b0) begin bad++; $display("FAIL rst_reg_rw: got %b want 0", REG_RW); end
    if (REG_ADDR !== 6'h00) begin bad++; $display("FAIL rst_reg_addr: got %h want 00", REG_ADDR); end
    if (REG_DATA_I !== 8'h00) begin bad++; $display("FAIL rst_reg_data_i: got %h want 00", REG_DATA_I); end
    if (VENDOR_ID !== 8'h00) begin bad++; $display("FAIL rst_vendor_id: got %h want 00", VENDOR_ID); end
    if (STEP !== 3'd0) begin bad++; $display("FAIL rst_step: got %0d want 0", STEP); end
    if (INIT_DONE !== 1'b0) begin bad++; $display("FAIL rst_init_done: got %b want 0", INIT_DONE); end
    if (INIT_ERR !== 1'b0) begin bad++; $display("FAIL rst_init_err: got %b want 0", INIT_ERR); end
  endtask

  task automatic test_nominal();
    bit hit;
    int sb;
    start_scn(8'h24, -1, 0, 0, FUNC, 0);
    wait_term(3000, hit);
    sb = 0;
    if (ops_q.size() != exp_n) sb++;
    else foreach (ops_q[i]) if (ops_q[i] != exp_steps[i]) sb++;
    total += 6;
    if (!hit) begin bad++; $display("FAIL nom_terminate: no terminal state within budget"); end
    if (INIT_DONE !== 1'b1) begin bad++; $display("FAIL nom_init_done: got %b want 1", INIT_DONE); end
    if (VENDOR_ID !== 8'h24) begin bad++; $display("FAIL nom_vendor_id: got %h want 24", VENDOR_ID); end
    if (ops_q.size() != 5) begin bad++; $display("FAIL nom_pulses: got %0d want 5", ops_q.size()); end
    if (sb != 0) begin bad++; $display("FAIL nom_sequence: %0d step mismatches", sb); end
    if (en_viol != 0) begin bad++; $display("FAIL nom_en_width: %0d multi-cycle strobes", en_viol); end
  endtask

  task automatic test_single_abort();
    bit hit, hit2;
    logic [7:0] vid;
    vid = 8'($urandom);
    start_scn(vid, 2, 1, 0, FUNC, 0);
    wait_ops(2, 500, hit);
    @(negedge CLK_60M) RESTART = 1'b1;
    @(negedge CLK_60M) RESTART = 1'b0;
    wait_term(3000, hit2);
    total += 5;
    if (!(hit && hit2)) begin bad++; $display("FAIL abort1_terminate: ops=%0b term=%0b", hit, hit2); end
    if (INIT_DONE !== 1'b1) begin bad++; $display("FAIL abort1_init_done: got %b want 1", INIT_DONE); end
    if (ops_q.size() != exp_n) begin bad++; $display("FAIL abort1_pulses: got %0d want %0d", ops_q.size(), exp_n); end
    if (attempts[2] != 2) begin bad++; $display("FAIL abort1_step2_tries: got %0d want 2", attempts[2]); end
    if (VENDOR_ID !== vid) begin bad++; $display("FAIL abort1_vendor_id: got %h want %h", VENDOR_ID, vid); end
  endtask

  task automatic test_persistent_abort();
    bit hit;
    start_scn(8'h24, 3, 99, 0, FUNC, 0);
    wait_term(3000, hit);
    total += 5;
    if (!hit) begin bad++; $display("FAIL abortN_terminate: no terminal state within budget"); end
    if (INIT_ERR !== 1'b1) begin bad++; $display("FAIL abortN_init_err: got %b want 1", INIT_ERR); end
    if (INIT_DONE !== 1'b0) begin bad++; $display("FAIL abortN_init_done: got %b want 0", INIT_DONE); end
    if (STEP !== 3'(exp_step)) begin bad++; $display("FAIL abortN_step: got %0d want %0d", STEP, exp_step); end
    if (attempts[3] != MAX_RETRY + 1) begin bad++; $display("FAIL abortN_step3_tries: got %0d want %0d", attempts[3], MAX_RETRY + 1); end
  endtask

  task automatic test_readback_mismatch();
    bit hit;
    start_scn(8'h24, -1, 0, 0, 8'h41, 0);
    wait_term(3000, hit);
    total += 4;
    if (!hit) begin bad++; $display("FAIL rdbk_terminate: no terminal state within budget"); end
    if (INIT_ERR !== 1'b1) begin bad++; $display("FAIL rdbk_init_err: got %b want 1", INIT_ERR); end
    if (INIT_DONE !== 1'b0) begin bad++; $display("FAIL rdbk_init_done: got %b want 0", INIT_DONE); end
    if (STEP !== 3'd4) begin bad++; $display("FAIL rdbk_step: got %0d want 4", STEP); end
  endtask

  task automatic test_timeout();
    bit hit;
    int elapsed;
    start_scn(8'h24, -1, 0, 0, FUNC, 1);
    wait_term(3000, hit);
    elapsed = cyc - s1_done_cyc;
    total += 4;
    if (!hit) begin bad++; $display("FAIL tmo_terminate: no terminal state within budget"); end
    if (INIT_ERR !== 1'b1) begin bad++; $display("FAIL tmo_init_err: got %b want 1", INIT_ERR); end
    if (STEP !== 3'd1) begin bad++; $display("FAIL tmo_step: got %0d want 1", STEP); end
    if (elapsed < TIMEOUT || elapsed > TIMEOUT + 4)
      begin bad++; $display("FAIL tmo_latency: got %0d cycles want %0d..%0d", elapsed, TIMEOUT, TIMEOUT + 4); end
    @(negedge CLK_60M);
    RESTART = 1'b1;
    cfg_hold = 0;
    @(negedge CLK_60M);
    RESTART = 1'b0;
    total += 2;
    if (STEP !== 3'd0) begin bad++; $display("FAIL tmo_restart_step: got %0d want 0", STEP); end
    if (INIT_ERR !== 1'b0) begin bad++; $display("FAIL tmo_restart_err: got %b want 0", INIT_ERR); end
    wait_term(3000, hit);
    total += 1;
    if (!(hit && INIT_DONE === 1'b1)) begin bad++; $display("FAIL tmo_rerun_done: got %b want 1", INIT_DONE); end
  endtask

  task automatic test_both_step0();
    bit hit, hit2;
    logic [7:0] vid;
    vid = 8'($urandom_range(0, 8'hED));
    start_scn(vid, 0, 1, 1, FUNC, 0);
    wait_ops(2, 500, hit);
    total += 3;
    if (!hit) begin bad++; $display("FAIL both_reissue: second strobe not seen"); end
    if (VENDOR_ID !== 8'h00) begin bad++; $display("FAIL both_vid_held: got %h want 00", VENDOR_ID); end
    if (ops_q.size() >= 2 && ops_q[1] != 0) begin bad++; $display("FAIL both_second_step: got %0d want 0", ops_q[1]); end
    wait_term(3000, hit2);
    total += 3;
    if (INIT_DONE !== 1'b1) begin bad++; $display("FAIL both_init_done: got %b want 1", INIT_DONE); end
    if (VENDOR_ID !== vid) begin bad++; $display("FAIL both_vendor_id: got %h want %h", VENDOR_ID, vid); end
    if (ops_q.size() != 6) begin bad++; $display("FAIL both_pulses: got %0d want 6", ops_q.size()); end
  endtask

  task automatic test_reset_midop();
    bit hit, hit2;
    start_scn(8'h5A, -1, 0, 0, FUNC, 0);
    wait_ops(3, 500, hit);
    @(negedge CLK_60M);
    NRST_A_USB = 1'b0;
    force_low = 1;
    #1;
    total += 3;
    if (!hit) begin bad++; $display("FAIL midrst_progress: third strobe not seen"); end
    if (REG_EN !== 1'b0) begin bad++; $display("FAIL midrst_reg_en: got %b want 0", REG_EN); end
    if (STEP !== 3'd0) begin bad++; $display("FAIL midrst_step: got %0d want 0", STEP); end
    @(posedge CLK_60M);
    phy_reset();
    model_run(-1, 0, FUNC, 0);
    @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
    repeat (20) @(negedge CLK_60M);
    total += 1;
    if (ops_q.size() != 0) begin bad++; $display("FAIL midrst_no_strobe: got %0d strobes want 0", ops_q.size()); end
    force_low = 0;
    wait_term(3000, hit2);
    total += 2;
    if (INIT_DONE !== 1'b1) begin bad++; $display("FAIL midrst_init_done: got %b want 1", INIT_DONE); end
    if (ops_q.size() != exp_n) begin bad++; $display("FAIL midrst_pulses: got %0d want %0d", ops_q.size(), exp_n); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      bit hit;
      int fs, fn, sb;
      bit both;
      logic [7:0] vid, rb;
      fs = $urandom_range(0, 5);
      if (fs == 5) fs = -1;
      fn = $urandom_range(0, 5);
      both = 1'($urandom_range(0, 1));
      vid = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? FUNC : 8'($urandom);
      start_scn(vid, fs, fn, both, rb, 0);
      wait_term(3000, hit);
      sb = 0;
      if (ops_q.size() != exp_n) sb++;
      else foreach (ops_q[i]) if (ops_q[i] != exp_steps[i]) sb++;
      total += 6;
      if (!hit) begin bad++; $display("FAIL rnd%0d_terminate: no terminal state", it); end
      if (INIT_DONE !== exp_done) begin bad++; $display("FAIL rnd%0d_init_done: got %b want %b", it, INIT_DONE, exp_done); end
      if (INIT_ERR !== !exp_done) begin bad++; $display("FAIL rnd%0d_init_err: got %b want %b", it, INIT_ERR, !exp_done); end
      if (STEP !== 3'(exp_step)) begin bad++; $display("FAIL rnd%0d_step: got %0d want %0d", it, STEP, exp_step); end
      if (VENDOR_ID !== (exp_vid_ok ? vid : 8'h00))
        begin bad++; $display("FAIL rnd%0d_vendor_id: got %h want %h", it, VENDOR_ID, exp_vid_ok ? vid : 8'h00); end
      if (sb != 0 || en_viol != 0)
        begin bad++; $display("FAIL rnd%0d_sequence: got %0d pulses (%0d diffs, %0d wide) want %0d", it, ops_q.size(), sb, en_viol, exp_n); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_abort();
    test_persistent_abort();
    test_readback_mismatch();
    test_timeout();
    test_both_step0();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
